// File: rtl/phase_frame_sched.sv
// Shared pwm period counter plus double-buffered phase bank: frames stream into a shadow
// buffer and are committed to the live phases atomically at the period boundary.
module phase_frame_sched #(
    parameter int unsigned CLK_FREQ = 256,
    parameter int unsigned OUT_FREQ = 1,
    parameter int unsigned NUM_CH   = 4,
    localparam int unsigned PERIOD  = CLK_FREQ / OUT_FREQ,
    localparam int unsigned CNT_W   = $clog2(PERIOD)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CNT_W-1:0]        in_data,
    input  logic                    in_last,
    output logic [CNT_W-1:0]        cnt,
    output logic [NUM_CH*CNT_W-1:0] phases,
    output logic [NUM_CH-1:0]       ch_en,
    output logic                    commit,
    output logic                    frame_err
);

    localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PERIOD - 1);

    typedef enum logic {StFill, StPend} state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q;
    logic [NUM_CH*CNT_W-1:0]   shadow_q;
    logic [NUM_CH*CNT_W-1:0]   phases_q;
    logic [IDX_W-1:0]          wr_idx_q;
    logic [NUM_CH-1:0]         ch_en_q;
    logic                      commit_q;
    logic                      frame_err_q;
    logic                      committed_once_q;

    logic hs;
    logic idx_at_last;
    logic frame_ok;
    logic frame_bad;
    logic cnt_wrap;
    logic do_commit;

    assign hs          = in_valid & in_ready;
    assign idx_at_last = (wr_idx_q == LAST_IDX);
    assign frame_ok    = hs & in_last & idx_at_last;
    // in_last disagreeing with the slot position means a short or a long frame
    assign frame_bad   = hs & (in_last ^ idx_at_last);
    assign cnt_wrap    = (cnt_q == CNT_MAX);
    assign do_commit   = (state_q == StPend) & (~enable | cnt_wrap);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFill;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFill: if (frame_ok)  state_d = StPend;
            StPend: if (do_commit) state_d = StFill;
            default: state_d = StFill;
        endcase
    end

    always_comb begin
        in_ready = (state_q == StFill);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q            <= '0;
            shadow_q         <= '0;
            phases_q         <= '0;
            wr_idx_q         <= '0;
            ch_en_q          <= '0;
            commit_q         <= 1'b0;
            frame_err_q      <= 1'b0;
            committed_once_q <= 1'b0;
        end else begin
            if (!enable || cnt_wrap) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (hs) begin
                if (frame_ok || frame_bad) begin
                    wr_idx_q <= '0;
                end else begin
                    wr_idx_q <= wr_idx_q + 1'b1;
                end
            end

            if (hs && !frame_bad) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (wr_idx_q == IDX_W'(k)) begin
                        shadow_q[k*CNT_W +: CNT_W] <= in_data;
                    end
                end
            end

            frame_err_q <= frame_bad;
            commit_q    <= do_commit;
            if (do_commit) begin
                phases_q         <= shadow_q;
                committed_once_q <= 1'b1;
            end

            ch_en_q <= {NUM_CH{enable & committed_once_q}};
        end
    end

    assign cnt       = cnt_q;
    assign phases    = phases_q;
    assign ch_en     = ch_en_q;
    assign commit    = commit_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_phase_frame_sched.sv
// Directed bench for phase_frame_sched: counter wrap, frame commit timing, malformed frames,
// back-pressure, enable drop while pending and asynchronous reset mid-frame.
module tb_phase_frame_sched;

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned NUM_CH = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    enable;
    logic                    in_valid;
    logic                    in_ready;
    logic [CNT_W-1:0]        in_data;
    logic                    in_last;
    logic [CNT_W-1:0]        cnt;
    logic [NUM_CH*CNT_W-1:0] phases;
    logic [NUM_CH-1:0]       ch_en;
    logic                    commit;
    logic                    frame_err;

    int n_checks = 0;
    int n_bad    = 0;
    int cyc;
    int cyc_pre;
    int ready_seen;

    phase_frame_sched #(
        .CLK_FREQ(256),
        .OUT_FREQ(1),
        .NUM_CH  (NUM_CH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .cnt      (cnt),
        .phases   (phases),
        .ch_en    (ch_en),
        .commit   (commit),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [CNT_W-1:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [CNT_W-1:0] w0, input logic [CNT_W-1:0] w1,
                              input logic [CNT_W-1:0] w2, input logic [CNT_W-1:0] w3);
        send_word(w0, 1'b0);
        send_word(w1, 1'b0);
        send_word(w2, 1'b0);
        send_word(w3, 1'b1);
    endtask

    // Advances until commit is seen; counts cycles and pre-commit cycles with in_ready high.
    task automatic wait_commit(output int cycles, output int ready_cnt);
        cycles    = 0;
        ready_cnt = 0;
        do begin
            tick();
            cycles++;
            if (!commit && in_ready) ready_cnt++;
        end while (!commit && cycles < 300);
        check("commit_seen", commit, 1'b1);
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        #1;
        check("rst_cnt", cnt, 0);
        check("rst_phases", phases, 0);
        check("rst_ch_en", ch_en, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_commit", commit, 0);
        check("rst_frame_err", frame_err, 0);
        tick();
        tick();
        rst    = 1'b0;
        enable = 1'b1;

        // 1: free-running counter and wrap
        check("t1_cnt0", cnt, 0);
        for (int i = 0; i < 255; i++) tick();
        check("t1_cnt255", cnt, 255);
        tick();
        check("t1_cnt_wrap", cnt, 0);
        check("t1_phases", phases, 0);
        check("t1_ch_en", ch_en, 0);
        check("t1_in_ready", in_ready, 1);

        // 2: good frame commits at the wrap edge
        send_frame(8'd10, 8'd20, 8'd30, 8'd247);
        check("t2_in_ready_pend", in_ready, 0);
        check("t2_cnt_after_frame", cnt, 4);
        wait_commit(cyc, ready_seen);
        check("t2_latency", cyc, 252);
        check("t2_cnt_at_commit", cnt, 0);
        check("t2_phases", phases, 32'hF71E140A);
        check("t2_ch_en_at_commit", ch_en, 0);
        check("t2_in_ready_back", in_ready, 1);
        tick();
        check("t2_ch_en", ch_en, 4'hF);
        check("t2_commit_pulse", commit, 0);

        // 3: short frame is discarded, next good frame still lands in order
        send_word(8'd5, 1'b0);
        send_word(8'd6, 1'b1);
        check("t3_frame_err", frame_err, 1);
        check("t3_phases_kept", phases, 32'hF71E140A);
        tick();
        check("t3_frame_err_pulse", frame_err, 0);
        check("t3_in_ready", in_ready, 1);
        send_frame(8'd1, 8'd2, 8'd3, 8'd4);
        check("t3_no_err_good", frame_err, 0);
        wait_commit(cyc, ready_seen);
        check("t3_latency", cyc, 248);
        check("t3_phases", phases, 32'h04030201);

        // 4: back-pressure while pending, second commit one period later
        send_frame(8'd11, 8'd12, 8'd13, 8'd14);
        in_valid = 1'b1;
        in_data  = 8'd21;
        in_last  = 1'b0;
        wait_commit(cyc_pre, ready_seen);
        check("t4_no_ready_pend", ready_seen, 0);
        check("t4_phases_a", phases, 32'h0E0D0C0B);
        check("t4_ready_after", in_ready, 1);
        tick();
        send_word(8'd22, 1'b0);
        send_word(8'd23, 1'b0);
        send_word(8'd24, 1'b1);
        check("t4_pend_b", in_ready, 0);
        wait_commit(cyc, ready_seen);
        check("t4_period", cyc + 4, 256);
        check("t4_phases_b", phases, 32'h18171615);

        // 5: dropping enable while pending commits on the next edge
        send_frame(8'd31, 8'd32, 8'd33, 8'd34);
        check("t5_pend", in_ready, 0);
        check("t5_cnt_before", cnt, 4);
        enable = 1'b0;
        tick();
        check("t5_cnt_zero", cnt, 0);
        check("t5_commit", commit, 1);
        check("t5_phases", phases, 32'h2221201F);
        check("t5_ch_en_off", ch_en, 0);
        tick();
        check("t5_commit_pulse", commit, 0);
        check("t5_cnt_held", cnt, 0);
        check("t5_ch_en_still_off", ch_en, 0);
        enable = 1'b1;
        tick();
        check("t5_ch_en_on", ch_en, 4'hF);
        check("t5_cnt_resume", cnt, 1);

        // 6: asynchronous reset with a partial frame loaded
        send_word(8'd40, 1'b0);
        send_word(8'd41, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_cnt", cnt, 0);
        check("t6_rst_phases", phases, 0);
        check("t6_rst_ch_en", ch_en, 0);
        check("t6_rst_in_ready", in_ready, 1);
        tick();
        rst = 1'b0;
        send_frame(8'd50, 8'd60, 8'd70, 8'd80);
        check("t6_no_err", frame_err, 0);
        check("t6_pend", in_ready, 0);
        wait_commit(cyc, ready_seen);
        check("t6_latency", cyc, 252);
        check("t6_phases", phases, 32'h50463C32);
        check("t6_ch_en_at_commit", ch_en, 0);
        tick();
        check("t6_ch_en", ch_en, 4'hF);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
